data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and the backing data memory. It consumes the memory-stage address and store data and returns load data. It raises `stall` to freeze the pipeline while a miss or write-through is outstanding. Backing memory is reached over a single-outstanding req/ack handshake of arbitrary latency.

---
 rtl/data_cache.sv | 162 ++++++++++++++++
 tb/tb_data_cache.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the pipeline memory stage and a single-outstanding backing memory.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_re, cpu_we           load / store request from the memory stage
//   cpu_addr, cpu_wdata      byte address (bits [1:0] ignored), store data
//   cpu_rdata, stall         load data (combinational), pipeline freeze (combinational)
//   mem_req, mem_we          registered backing-memory request and direction
//   mem_addr, mem_wdata      registered word-aligned address and write data
//   mem_rdata, mem_ack       backing-memory read data and one-cycle completion
//   hit_count, miss_count    saturating load hit / miss counters
module data_cache #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_BITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;
  localparam int unsigned TAG_W = WIDTH - IDX_BITS - 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [IDX_BITS-1:0] w_m_idx;
  logic [TAG_W-1:0]    w_m_tag;
  logic                w_m_hit;

  logic w_load_hit;
  logic w_load_miss;
  logic w_start_wr;
  logic w_fill;
  logic w_wr_update;

  // Lookup for the incoming request and for the latched request address
  assign w_idx   = cpu_addr[IDX_BITS+1:2];
  assign w_tag   = cpu_addr[WIDTH-1:IDX_BITS+2];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_m_idx = mem_addr[IDX_BITS+1:2];
  assign w_m_tag = mem_addr[WIDTH-1:IDX_BITS+2];
  assign w_m_hit = r_valid[w_m_idx] && (r_tag[w_m_idx] == w_m_tag);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, stall and load data
  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    cpu_rdata   = '0;
    w_load_hit  = 1'b0;
    w_load_miss = 1'b0;
    w_start_wr  = 1'b0;
    w_fill      = 1'b0;
    w_wr_update = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_we) begin
          // store wins over a simultaneous load
          w_start_wr = 1'b1;
          stall      = 1'b1;
          w_next     = S_WR_WAIT;
        end else if (cpu_re) begin
          if (w_hit) begin
            cpu_rdata  = r_data[w_idx];
            w_load_hit = 1'b1;
          end else begin
            stall       = 1'b1;
            w_load_miss = 1'b1;
            w_next      = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (mem_ack) begin
          // forward fill data in the ack cycle so the pipeline resumes at once
          cpu_rdata = mem_rdata;
          w_fill    = 1'b1;
          w_next    = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (mem_ack) begin
          w_wr_update = w_m_hit;
          w_next      = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory request registers, counters and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      r_valid    <= '0;
    end else begin
      if (w_start_wr || w_load_miss) begin
        mem_req  <= 1'b1;
        mem_we   <= w_start_wr;
        mem_addr <= cpu_addr & ~WIDTH'(3);
        if (w_start_wr) mem_wdata <= cpu_wdata;
      end else if (r_state != S_IDLE && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (w_load_hit && hit_count != '1)   hit_count  <= hit_count + 32'd1;
      if (w_load_miss && miss_count != '1) miss_count <= miss_count + 32'd1;
      if (w_fill) r_valid[w_m_idx] <= 1'b1;
    end
  end

  // Tag and data storage (not reset); a fill replaces the line unconditionally
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_m_idx]  <= w_m_tag;
        r_data[w_m_idx] <= mem_rdata;
      end else if (w_wr_update) begin
        r_data[w_m_idx] <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed load/store scenarios with a
// scripted backing-memory responder.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total;
  int bad;

  data_cache #(.WIDTH(32), .IDX_BITS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access starting just after a posedge; the responder acks
  // lat cycles after mem_req rises. Returns stall cycles, load data on the
  // release cycle, whether the request bus looked right, and a timeout flag.
  task automatic run_access(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input logic [31:0] rd,
                            output int stall_cyc, output logic [31:0] rdata_out,
                            output logic req_ok, output logic timeout);
    int  cyc;
    logic done;
    cpu_re    = re;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_rdata = rd;
    stall_cyc = 0;
    rdata_out = '0;
    req_ok    = 1'b1;
    done      = 1'b0;
    cyc       = 0;
    while (!done && cyc < 64) begin
      mem_ack = (cyc == lat + 1);
      @(negedge clk);
      if (cyc == 0 && mem_req !== 1'b0) req_ok = 1'b0;
      if (stall === 1'b0) begin
        rdata_out = cpu_rdata;
        done      = 1'b1;
      end else begin
        stall_cyc++;
        if (cyc > 0) begin
          if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== (addr & 32'hFFFF_FFFC))
            req_ok = 1'b0;
          if (we && mem_wdata !== wdata) req_ok = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    timeout = !done;
    cpu_re  = 1'b0;
    cpu_we  = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0; mem_ack = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem_bus req=%b we=%b addr=%h wdata=%h required 0 0 0 0",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_counters hit=%0d miss=%0d required 0 0", hit_count, miss_count);
    end
    total++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle_outputs stall=%b rdata=%h required 0 0", stall, cpu_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_miss_hit();
    int sc; logic [31:0] rdv; logic ok; logic to;
    run_access(1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, sc, rdv, ok, to);
    total++;
    if (to || sc != 4 || rdv !== 32'hDEADBEEF || !ok) begin
      bad++;
      $display("FAIL miss_0x100 stall=%0d rdata=%h bus_ok=%b timeout=%b required 4 deadbeef 1 0",
               sc, rdv, ok, to);
    end
    total++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      bad++;
      $display("FAIL miss_count_1 hit=%0d miss=%0d required 0 1", hit_count, miss_count);
    end
    // back-to-back with the fill: must hit
    run_access(1, 0, 32'h100, 32'h0, 3, 32'h0, sc, rdv, ok, to);
    total++;
    if (to || sc != 0 || rdv !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL hit_0x100 stall=%0d rdata=%h required 0 deadbeef", sc, rdv);
    end
    total++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      bad++;
      $display("FAIL hit_count_1 hit=%0d miss=%0d required 1 1", hit_count, miss_count);
    end
  endtask

  task automatic test_store_hit();
    int sc; logic [31:0] rdv; logic ok; logic to;
    run_access(0, 1, 32'h100, 32'hCAFEF00D, 2, 32'h0, sc, rdv, ok, to);
    total++;
    if (to || sc != 3 || !ok) begin
      bad++;
      $display("FAIL store_0x100 stall=%0d bus_ok=%b timeout=%b required 3 1 0", sc, ok, to);
    end
    run_access(1, 0, 32'h100, 32'h0, 2, 32'h0, sc, rdv, ok, to);
    total++;
    if (to || sc != 0 || rdv !== 32'hCAFEF00D || !ok) begin
      bad++;
      $display("FAIL load_after_store stall=%0d rdata=%h required 0 cafef00d", sc, rdv);
    end
    total++;
    if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
      bad++;
      $display("FAIL counts_after_store hit=%0d miss=%0d required 2 1", hit_count, miss_count);
    end
  endtask

  task automatic test_store_no_allocate();
    int sc; logic [31:0] rdv; logic ok; logic to;
    run_access(0, 1, 32'h200, 32'h12345678, 1, 32'h0, sc, rdv, ok, to);
    total++;
    if (to || sc != 2 || !ok) begin
      bad++;
      $display("FAIL store_0x200 stall=%0d bus_ok=%b required 2 1", sc, ok);
    end
    run_access(1, 0, 32'h200, 32'h0, 2, 32'h55AA0000, sc, rdv, ok, to);
    total++;
    if (to || sc != 3 || rdv !== 32'h55AA0000 || !ok) begin
      bad++;
      $display("FAIL load_0x200_misses stall=%0d rdata=%h required 3 55aa0000", sc, rdv);
    end
    total++;
    if (miss_count !== 32'd2 || hit_count !== 32'd2) begin
      bad++;
      $display("FAIL counts_no_alloc hit=%0d miss=%0d required 2 2", hit_count, miss_count);
    end
  endtask

  task automatic test_alias();
    int sc1, sc2, sc3, sc4; logic [31:0] r1, r2, r3, r4; logic ok1, ok2, ok3, ok4; logic t1, t2, t3, t4;
    run_access(1, 0, 32'h100, 32'h0, 1, 32'hCAFEF00D, sc1, r1, ok1, t1);
    run_access(1, 0, 32'h200, 32'h0, 0, 32'h77770000, sc2, r2, ok2, t2);
    run_access(1, 0, 32'h100, 32'h0, 2, 32'h11112222, sc3, r3, ok3, t3);
    total++;
    if (t1 || t2 || t3 || sc1 != 2 || sc2 != 1 || sc3 != 3 || !ok1 || !ok2 || !ok3) begin
      bad++;
      $display("FAIL alias_stalls s=%0d,%0d,%0d ok=%b%b%b required 2,1,3 111", sc1, sc2, sc3, ok1, ok2, ok3);
    end
    total++;
    if (r1 !== 32'hCAFEF00D || r2 !== 32'h77770000 || r3 !== 32'h11112222) begin
      bad++;
      $display("FAIL alias_data %h %h %h required cafef00d 77770000 11112222", r1, r2, r3);
    end
    total++;
    if (miss_count !== 32'd5 || hit_count !== 32'd2) begin
      bad++;
      $display("FAIL alias_counts hit=%0d miss=%0d required 2 5", hit_count, miss_count);
    end
    run_access(1, 0, 32'h100, 32'h0, 2, 32'h0, sc4, r4, ok4, t4);
    total++;
    if (t4 || sc4 != 0 || r4 !== 32'h11112222) begin
      bad++;
      $display("FAIL alias_refill_hit stall=%0d rdata=%h required 0 11112222", sc4, r4);
    end
  endtask

  task automatic test_reset_mid();
    int sc; logic [31:0] rdv; logic ok; logic to;
    cpu_re = 1; cpu_addr = 32'h300;
    @(posedge clk);
    #1;
    cpu_re = 0;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rd_wait_entered mem_req=%b required 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid req=%b stall=%b rdata=%h required 0 0 0", mem_req, stall, cpu_rdata);
    end
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || miss_count !== 32'd0 || hit_count !== 32'd0) begin
      bad++;
      $display("FAIL late_ack_ignored req=%b hit=%0d miss=%0d required 0 0 0", mem_req, hit_count, miss_count);
    end
    @(posedge clk);
    #1;
    run_access(1, 0, 32'h300, 32'h0, 1, 32'h03000300, sc, rdv, ok, to);
    total++;
    if (to || sc != 2 || rdv !== 32'h03000300 || miss_count !== 32'd1 || !ok) begin
      bad++;
      $display("FAIL miss_after_reset stall=%0d rdata=%h miss=%0d required 2 03000300 1", sc, rdv, miss_count);
    end
  endtask

  task automatic test_re_we_priority();
    int sc; logic [31:0] rdv; logic ok; logic to;
    logic [31:0] h0, m0;
    h0 = hit_count;
    m0 = miss_count;
    run_access(1, 1, 32'h40, 32'h0BADF00D, 1, 32'h0, sc, rdv, ok, to);
    total++;
    if (to || sc != 2 || !ok || rdv !== 32'h0) begin
      bad++;
      $display("FAIL re_we_store stall=%0d bus_ok=%b rdata=%h required 2 1 0", sc, ok, rdv);
    end
    total++;
    if (hit_count !== h0 || miss_count !== m0) begin
      bad++;
      $display("FAIL re_we_counts hit=%0d miss=%0d required %0d %0d", hit_count, miss_count, h0, m0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    #1;
    test_reset();
    test_load_miss_hit();
    test_store_hit();
    test_store_no_allocate();
    test_alias();
    test_reset_mid();
    test_re_we_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
